bg_layer_sdr_arbiter: RTL and testbench
=======================================

BG_LAYER_SDR_ARBITER -- requirements
Module: bg_layer_sdr_arbiter

Interface
REQ-001 Parameter N_REQ, default 3, number of background-layer requesters.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before abort (8-bit counter).
REQ-003 CLK_32M  in  1  single clock; all logic on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 req_addr  in  N_REQ x 21  per-requester SDRAM word address; sampled only with req_strobe.
REQ-006 req_strobe  in  N_REQ  per-requester single-cycle request pulse (layer sdr_req).
REQ-007 req_rdy  out  N_REQ  per-requester single-cycle data-valid pulse (layer sdr_rdy).
REQ-008 req_data  out  32  shared return data; valid when any req_rdy bit is high.
REQ-009 sdr_addr  out  21  address to the SDRAM channel.
REQ-010 sdr_req  out  1  single-cycle request pulse to the SDRAM channel.
REQ-011 sdr_rdy  in  1  single-cycle completion pulse from the SDRAM channel.
REQ-012 sdr_data  in  32  SDRAM read data; valid with sdr_rdy.
REQ-013 overrun  out  N_REQ  sticky flag: requester strobed while its previous request was still pending.
REQ-014 timeout_err  out  1  sticky flag: a TIMEOUT abort occurred.

Function
REQ-015 Each requester SHALL own a 1-deep pending slot (valid bit + 21-bit address), loaded on the edge after req_strobe.
REQ-016 A strobe on a valid slot SHALL overwrite the address (latest wins) and set overrun[i].
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT.
REQ-018 IDLE: if any slot valid, grant the first valid slot at or after rr_ptr (wrapping modulo N_REQ), register its address into sdr_addr, clear that slot, go to ISSUE; otherwise stay in IDLE.
REQ-019 ISSUE: sdr_req=1 for exactly this one cycle; go to WAIT; clear the wait counter.
REQ-020 WAIT: on sdr_rdy, latch sdr_data into req_data, pulse req_rdy[grant] on the next cycle, set rr_ptr=grant+1 (wrapping), go to IDLE.
REQ-021 WAIT: if the counter reaches TIMEOUT without sdr_rdy, set timeout_err, advance rr_ptr, go to IDLE with no req_rdy pulse.
REQ-022 sdr_rdy outside WAIT SHALL be ignored.
REQ-023 A strobe in the same cycle the slot is cleared by grant SHALL win: the slot stays valid with the new address, and overrun is not set.
REQ-024 Minimum latency: strobe at cycle N, slot valid at N+1, sdr_req at N+2, req_rdy one cycle after sdr_rdy.
REQ-025 At most one SDRAM request SHALL be outstanding; sdr_addr SHALL stay stable from ISSUE until the FSM leaves WAIT.
REQ-026 req_rdy SHALL be one-hot or zero; req_data SHALL hold its value until the next sdr_rdy accepted in WAIT.

Reset
REQ-027 RESET_N low SHALL asynchronously force the following: FSM to IDLE; all slots invalid; rr_ptr=0; sdr_req=0; req_rdy=0; sdr_addr=0; req_data=0; overrun=0; timeout_err=0; wait counter=0.
REQ-028 Reset during WAIT SHALL drop the transaction; a late sdr_rdy after release SHALL be ignored per REQ-022.

Structure
REQ-029 The FSM state enum and the SDR address width (21) SHALL live in the shared M92 package.
REQ-030 The round-robin priority pick (valid vector + rr_ptr -> grant, any) SHALL be one combinational sub-module, rr_pick.

Verification
REQ-031 Single request: strobe 0 with addr 0x012340 -> sdr_req 2 cycles later with sdr_addr 0x012340; sdr_rdy with data 0xDEADBEEF -> req_rdy=3'b001 next cycle, req_data 0xDEADBEEF.
REQ-032 Simultaneous strobes on 0, 1 and 2 from reset -> grants in order 0, 1, 2, each waiting for its sdr_rdy; no overlap on sdr_req.
REQ-033 Fairness: requester 0 strobes continuously while 2 is pending after grant 0 -> next grant is 2, not 0.
REQ-034 Overrun: strobe 1 twice (0x100, then 0x200) while the FSM is in WAIT for 0 -> sdr_addr later shows 0x200 only; overrun=3'b010.
REQ-035 Timeout: no sdr_rdy for 255 cycles -> timeout_err=1, no req_rdy, FSM returns to IDLE and serves the next pending slot.
REQ-036 Reset in WAIT, then sdr_rdy after release -> no req_rdy; all outputs at reset values.

Source files
------------

// File: rtl/bg_layer_sdr_arbiter_pkg.sv
// Shared types and widths for the background-layer SDRAM arbiter.
package bg_layer_sdr_arbiter_pkg;

  localparam int unsigned SDR_AW  = 21;  // SDRAM word address width
  localparam int unsigned SDR_DW  = 32;  // SDRAM read data width
  localparam int unsigned WAIT_CW = 8;   // WAIT-state watchdog counter width

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // One-deep pending request slot per requester
  typedef struct packed {
    logic              vld;
    logic [SDR_AW-1:0] addr;
  } slot_t;

endpackage

// File: rtl/bg_layer_sdr_arbiter_rr_pick.sv
// Round-robin priority pick: first set bit of valid at or after ptr,
// wrapping modulo N_REQ.
//   valid   : per-requester pending bits
//   ptr     : round-robin start index (0..N_REQ-1)
//   grant_c : selected index (combinational)
//   any_c   : some bit of valid is set (combinational)
module rr_pick #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_c,
  output logic             any_c
);

  logic [31:0] idx;

  // Scan N_REQ candidates starting at ptr; the first valid one wins.
  always_comb begin
    grant_c = '0;
    any_c   = 1'b0;
    idx     = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + 32'(k);
      if (idx >= 32'(N_REQ)) idx = idx - 32'(N_REQ);
      if (!any_c && valid[idx[IDX_W-1:0]]) begin
        any_c   = 1'b1;
        grant_c = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bg_layer_sdr_arbiter.sv
// Arbitrates N_REQ background-layer read requesters onto one SDRAM channel,
// one outstanding request at a time, with round-robin fairness and a WAIT
// watchdog.
//   CLK_32M, RESET_N : clock, asynchronous active-low reset
//   req_addr/strobe  : per-requester address and single-cycle request pulse
//   req_rdy/req_data : per-requester data-valid pulse and shared read data
//   sdr_addr/sdr_req : request to the SDRAM channel
//   sdr_rdy/sdr_data : completion pulse and read data from the channel
//   overrun          : sticky, requester strobed while still pending
//   timeout_err      : sticky, a WAIT watchdog abort happened
module bg_layer_sdr_arbiter
  import bg_layer_sdr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                          CLK_32M,
  input  logic                          RESET_N,
  input  logic [N_REQ-1:0][SDR_AW-1:0]  req_addr,
  input  logic [N_REQ-1:0]              req_strobe,
  output logic [N_REQ-1:0]              req_rdy,
  output logic [SDR_DW-1:0]             req_data,
  output logic [SDR_AW-1:0]             sdr_addr,
  output logic                          sdr_req,
  input  logic                          sdr_rdy,
  input  logic [SDR_DW-1:0]             sdr_data,
  output logic [N_REQ-1:0]              overrun,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // WAIT lasts at most TIMEOUT cycles; abort on the last one.
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(TIMEOUT - 1);

  arb_state_e          state;
  arb_state_e          state_nxt;
  slot_t               slot [N_REQ];
  logic [N_REQ-1:0]    slot_vld_c;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    grant_q;
  logic [IDX_W-1:0]    grant_inc_c;
  logic [IDX_W-1:0]    pick_grant_c;
  logic                pick_any_c;
  logic                take_c;
  logic                accept_c;
  logic                expire_c;
  logic [WAIT_CW-1:0]  wait_cnt;

  // Gather slot valid bits for the picker
  always_comb begin
    slot_vld_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      slot_vld_c[i] = slot[i].vld;
    end
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .valid   (slot_vld_c),
    .ptr     (rr_ptr),
    .grant_c (pick_grant_c),
    .any_c   (pick_any_c)
  );

  // Round-robin pointer advances to the slot after the one just served
  assign grant_inc_c = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  // Next-state and transaction events
  always_comb begin
    state_nxt = state;
    take_c    = 1'b0;
    accept_c  = 1'b0;
    expire_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_any_c) begin
          take_c    = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (sdr_rdy) begin
          accept_c  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          expire_c  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Pending slots: a strobe beats a same-cycle grant clear, and only counts
  // as an overrun when the slot is not being handed out on that edge.
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        slot[i] <= '0;
      end
      overrun <= '0;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req_strobe[i]) begin
          slot[i].vld  <= 1'b1;
          slot[i].addr <= req_addr[i];
          if (slot[i].vld && !(take_c && (pick_grant_c == IDX_W'(i)))) begin
            overrun[i] <= 1'b1;
          end
        end else if (take_c && (pick_grant_c == IDX_W'(i))) begin
          slot[i].vld <= 1'b0;
        end
      end
    end
  end

  // SDRAM request, watchdog and return path
  always_ff @(posedge CLK_32M or negedge RESET_N) begin
    if (!RESET_N) begin
      sdr_req     <= 1'b0;
      sdr_addr    <= '0;
      grant_q     <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      req_rdy     <= '0;
      req_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      sdr_req <= take_c;
      req_rdy <= '0;
      if (take_c) begin
        sdr_addr <= slot[pick_grant_c].addr;
        grant_q  <= pick_grant_c;
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + WAIT_CW'(1);
      end
      if (accept_c) begin
        req_rdy  <= N_REQ'(1) << grant_q;
        req_data <= sdr_data;
        rr_ptr   <= grant_inc_c;
      end
      if (expire_c) begin
        timeout_err <= 1'b1;
        rr_ptr      <= grant_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_bg_layer_sdr_arbiter.sv
// Self-checking bench for bg_layer_sdr_arbiter: a cycle vector table, hand
// sequences for arbitration/timeout/reset corners, and a randomized run
// against a transaction-level reference model.
module tb_bg_layer_sdr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 21;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0][AW-1:0] req_addr;
  logic [N-1:0]         req_strobe;
  logic [N-1:0]         req_rdy;
  logic [31:0]          req_data;
  logic [AW-1:0]        sdr_addr;
  logic                 sdr_req;
  logic                 sdr_rdy;
  logic [31:0]          sdr_data;
  logic [N-1:0]         overrun;
  logic                 timeout_err;

  int n_vec;
  int n_bad;

  bg_layer_sdr_arbiter #(.N_REQ(N), .TIMEOUT(255)) dut (
    .CLK_32M     (clk),
    .RESET_N     (rst_n),
    .req_addr    (req_addr),
    .req_strobe  (req_strobe),
    .req_rdy     (req_rdy),
    .req_data    (req_data),
    .sdr_addr    (sdr_addr),
    .sdr_req     (sdr_req),
    .sdr_rdy     (sdr_rdy),
    .sdr_data    (sdr_data),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  stb;
    logic [20:0] addr;
    logic        rdy;
    logic [31:0] data;
    logic        q;
    logic [20:0] sa;
    logic [2:0]  rr;
    logic [31:0] rd;
    logic [2:0]  ov;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic [2:0] stb, logic [20:0] addr, logic rdy, logic [31:0] data,
                              logic q, logic [20:0] sa, logic [2:0] rr, logic [31:0] rd,
                              logic [2:0] ov);
    vec_t v;
    v.stb = stb; v.addr = addr; v.rdy = rdy; v.data = data;
    v.q = q; v.sa = sa; v.rr = rr; v.rd = rd; v.ov = ov;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req_strobe = '0;
    req_addr   = '0;
    sdr_rdy    = 1'b0;
    sdr_data   = '0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, ".sdr_req"},     32'(sdr_req),     32'd0);
    check({tag, ".sdr_addr"},    32'(sdr_addr),    32'd0);
    check({tag, ".req_rdy"},     32'(req_rdy),     32'd0);
    check({tag, ".req_data"},    req_data,         32'd0);
    check({tag, ".overrun"},     32'(overrun),     32'd0);
    check({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  // Bounded wait for sdr_req
  task automatic wait_req(string name, int maxc);
    int c;
    c = 0;
    while (!sdr_req && c < maxc) begin
      tick();
      c++;
    end
    check({name, ".sdr_req_seen"}, 32'(sdr_req), 32'd1);
  endtask

  // Called in the ISSUE cycle: hold WAIT for `hold` cycles, then complete
  task automatic serve(string name, int hold, logic [31:0] data, logic [2:0] exp_rdy);
    logic [AW-1:0] a0;
    bit            bad;
    a0  = sdr_addr;
    bad = 1'b0;
    tick();
    repeat (hold) begin
      if (sdr_req || sdr_addr != a0 || req_rdy != 0) bad = 1'b1;
      tick();
    end
    check({name, ".wait_quiet"}, 32'(bad), 32'd0);
    sdr_rdy  = 1'b1;
    sdr_data = data;
    tick();
    sdr_rdy  = 1'b0;
    check({name, ".req_rdy"},  32'(req_rdy), 32'(exp_rdy));
    check({name, ".req_data"}, req_data,     data);
  endtask

  // Reference model state for the randomized run
  bit          m_pv  [N];
  logic [20:0] m_pa  [N];
  int          m_ptr;
  int          m_phase;   // 0: no request in flight, 1: request cycle, 2: awaiting data
  int          m_g;
  int          m_age;
  int          m_dly;
  logic [20:0] m_ea;
  logic [31:0] m_ed;
  logic [2:0]  m_ov;
  logic [2:0]  m_rr;

  initial begin
    n_vec = 0;
    n_bad = 0;

    do_reset();
    check_reset_vals("reset");

    // Cycle table: single request, ignored sdr_rdy outside WAIT, overrun,
    // same-cycle strobe/grant, round-robin pointer movement.
    tbl[0]  = mk(3'b001, 21'h012340, 1'b0, 32'h0,        1'b0, 21'h000000, 3'b000, 32'h0,        3'b000);
    tbl[1]  = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b1, 21'h012340, 3'b000, 32'h0,        3'b000);
    tbl[2]  = mk(3'b000, 21'h000000, 1'b1, 32'h11111111, 1'b0, 21'h012340, 3'b000, 32'h0,        3'b000);
    tbl[3]  = mk(3'b000, 21'h000000, 1'b1, 32'hDEADBEEF, 1'b0, 21'h012340, 3'b001, 32'hDEADBEEF, 3'b000);
    tbl[4]  = mk(3'b000, 21'h000000, 1'b1, 32'hCAFEF00D, 1'b0, 21'h012340, 3'b000, 32'hDEADBEEF, 3'b000);
    tbl[5]  = mk(3'b001, 21'h000AAA, 1'b0, 32'h0,        1'b0, 21'h012340, 3'b000, 32'hDEADBEEF, 3'b000);
    tbl[6]  = mk(3'b010, 21'h000100, 1'b0, 32'h0,        1'b1, 21'h000AAA, 3'b000, 32'hDEADBEEF, 3'b000);
    tbl[7]  = mk(3'b010, 21'h000200, 1'b0, 32'h0,        1'b0, 21'h000AAA, 3'b000, 32'hDEADBEEF, 3'b010);
    tbl[8]  = mk(3'b000, 21'h000000, 1'b1, 32'h00000001, 1'b0, 21'h000AAA, 3'b001, 32'h00000001, 3'b010);
    tbl[9]  = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b1, 21'h000200, 3'b000, 32'h00000001, 3'b010);
    tbl[10] = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b0, 21'h000200, 3'b000, 32'h00000001, 3'b010);
    tbl[11] = mk(3'b000, 21'h000000, 1'b1, 32'h00000002, 1'b0, 21'h000200, 3'b010, 32'h00000002, 3'b010);
    tbl[12] = mk(3'b100, 21'h000333, 1'b0, 32'h0,        1'b0, 21'h000200, 3'b000, 32'h00000002, 3'b010);
    tbl[13] = mk(3'b100, 21'h000444, 1'b0, 32'h0,        1'b1, 21'h000333, 3'b000, 32'h00000002, 3'b010);
    tbl[14] = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b0, 21'h000333, 3'b000, 32'h00000002, 3'b010);
    tbl[15] = mk(3'b000, 21'h000000, 1'b1, 32'h00000003, 1'b0, 21'h000333, 3'b100, 32'h00000003, 3'b010);
    tbl[16] = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b1, 21'h000444, 3'b000, 32'h00000003, 3'b010);
    tbl[17] = mk(3'b000, 21'h000000, 1'b0, 32'h0,        1'b0, 21'h000444, 3'b000, 32'h00000003, 3'b010);
    tbl[18] = mk(3'b000, 21'h000000, 1'b1, 32'h00000004, 1'b0, 21'h000444, 3'b100, 32'h00000004, 3'b010);

    for (int k = 0; k < 19; k++) begin
      for (int i = 0; i < int'(N); i++) begin
        req_addr[i] = tbl[k].stb[i] ? tbl[k].addr : 21'($urandom);
      end
      req_strobe = tbl[k].stb;
      sdr_rdy    = tbl[k].rdy;
      sdr_data   = tbl[k].data;
      tick();
      check($sformatf("tbl[%0d].sdr_req", k),     32'(sdr_req),     32'(tbl[k].q));
      check($sformatf("tbl[%0d].sdr_addr", k),    32'(sdr_addr),    32'(tbl[k].sa));
      check($sformatf("tbl[%0d].req_rdy", k),     32'(req_rdy),     32'(tbl[k].rr));
      check($sformatf("tbl[%0d].req_data", k),    req_data,         tbl[k].rd);
      check($sformatf("tbl[%0d].overrun", k),     32'(overrun),     32'(tbl[k].ov));
      check($sformatf("tbl[%0d].timeout_err", k), 32'(timeout_err), 32'd0);
    end
    req_strobe = '0;
    sdr_rdy    = 1'b0;

    // Simultaneous strobes from reset: served 0, 1, 2 without overlap
    do_reset();
    req_addr[0] = 21'h000010;
    req_addr[1] = 21'h000011;
    req_addr[2] = 21'h000012;
    req_strobe  = 3'b111;
    tick();
    req_strobe  = '0;
    for (int k = 0; k < 3; k++) begin
      wait_req($sformatf("simul%0d", k), 6);
      check($sformatf("simul%0d.sdr_addr", k), 32'(sdr_addr), 32'h10 + 32'(k));
      serve($sformatf("simul%0d", k), 3, 32'hA0 + 32'(k), 3'(1 << k));
    end
    check("simul.overrun", 32'(overrun), 32'd0);

    // Fairness: requester 0 strobing every cycle does not starve requester 2
    do_reset();
    req_addr[0] = 21'h000A00;
    req_addr[2] = 21'h000C02;
    req_strobe  = 3'b101;
    tick();
    req_strobe  = 3'b001;
    wait_req("fair_a", 5);
    check("fair_a.sdr_addr", 32'(sdr_addr), 32'h000A00);
    serve("fair_a", 1, 32'h00000010, 3'b001);
    wait_req("fair_b", 5);
    check("fair_b.sdr_addr", 32'(sdr_addr), 32'h000C02);
    serve("fair_b", 1, 32'h00000020, 3'b100);
    wait_req("fair_c", 5);
    check("fair_c.sdr_addr", 32'(sdr_addr), 32'h000A00);
    req_strobe = '0;
    serve("fair_c", 1, 32'h00000030, 3'b001);
    check("fair.overrun", 32'(overrun), 32'b001);

    // Timeout: no completion, abort, then the next pending slot is served
    do_reset();
    req_addr[0] = 21'h0000A0;
    req_addr[1] = 21'h0000B1;
    req_strobe  = 3'b011;
    tick();
    req_strobe  = '0;
    wait_req("to_first", 5);
    check("to_first.sdr_addr", 32'(sdr_addr), 32'h0000A0);
    begin
      int c;
      bit bad;
      c   = 0;
      bad = 1'b0;
      while (!timeout_err && c < 400) begin
        if (req_rdy != 0 || (c > 0 && sdr_req)) bad = 1'b1;
        tick();
        c++;
      end
      check("to.timeout_err", 32'(timeout_err), 32'd1);
      check("to.cycles_in_window", 32'(c >= 250 && c <= 260), 32'd1);
      check("to.no_req_rdy", 32'(bad || req_rdy != 0), 32'd0);
    end
    wait_req("to_next", 5);
    check("to_next.sdr_addr", 32'(sdr_addr), 32'h0000B1);
    serve("to_next", 2, 32'h12345678, 3'b010);
    check("to.sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT drops the transaction; late sdr_rdy is ignored
    req_addr[0] = 21'h001234;
    req_strobe  = 3'b001;
    tick();
    req_strobe  = '0;
    wait_req("rstw", 5);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rstw.async");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    sdr_rdy  = 1'b1;
    sdr_data = 32'h55555555;
    tick();
    sdr_rdy  = 1'b0;
    check_reset_vals("rstw.late_rdy");
    tick();
    check("rstw.no_reissue", 32'(sdr_req), 32'd0);

    // Randomized run against the reference model
    do_reset();
    for (int i = 0; i < int'(N); i++) begin
      m_pv[i] = 1'b0;
      m_pa[i] = '0;
    end
    m_ptr = 0; m_phase = 0; m_g = 0; m_age = 0; m_dly = 0;
    m_ea = '0; m_ed = '0; m_ov = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [2:0] stb;
      logic       rdy;
      for (int i = 0; i < int'(N); i++) begin
        stb[i]      = ($urandom_range(0, 4) == 0);
        req_addr[i] = 21'($urandom);
      end
      rdy = 1'b0;
      if (m_phase == 2 && m_age >= m_dly)          rdy = 1'b1;
      else if (m_phase != 2 && $urandom_range(0, 7) == 0) rdy = 1'b1;
      req_strobe = stb;
      sdr_rdy    = rdy;
      sdr_data   = $urandom;

      // Effect of this clock edge
      m_rr = '0;
      if (m_phase == 2) begin
        if (rdy) begin
          m_rr[m_g] = 1'b1;
          m_ed      = sdr_data;
          m_ptr     = (m_g + 1) % int'(N);
          m_phase   = 0;
        end else begin
          m_age++;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_age   = 0;
        m_dly   = int'($urandom_range(0, 5));
      end else begin
        for (int k = int'(N) - 1; k >= 0; k--) begin
          int j;
          j = (m_ptr + k) % int'(N);
          if (m_pv[j]) m_g = j;
        end
        if (m_pv[m_g] && (m_pv[0] || m_pv[1] || m_pv[2])) begin
          m_ea       = m_pa[m_g];
          m_pv[m_g]  = 1'b0;
          m_phase    = 1;
        end
      end
      for (int i = 0; i < int'(N); i++) begin
        if (stb[i]) begin
          if (m_pv[i]) m_ov[i] = 1'b1;
          m_pv[i] = 1'b1;
          m_pa[i] = req_addr[i];
        end
      end

      tick();
      req_strobe = '0;
      sdr_rdy    = 1'b0;
      check($sformatf("rnd[%0d].sdr_req", cyc),     32'(sdr_req),     32'(m_phase == 1));
      check($sformatf("rnd[%0d].sdr_addr", cyc),    32'(sdr_addr),    32'(m_ea));
      check($sformatf("rnd[%0d].req_rdy", cyc),     32'(req_rdy),     32'(m_rr));
      check($sformatf("rnd[%0d].req_data", cyc),    req_data,         m_ed);
      check($sformatf("rnd[%0d].overrun", cyc),     32'(overrun),     32'(m_ov));
      check($sformatf("rnd[%0d].timeout_err", cyc), 32'(timeout_err), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
